// File: rtl/reorder_buffer_mp.sv
// In-order-commit reorder buffer with multiple writeback ports.
// Forwards results to the PRF, frees old pregs, flushes on mispredict.
module reorder_buffer_mp #(
  parameter int DEPTH    = 16,
  parameter int IDW      = $clog2(DEPTH),
  parameter int DATA_W   = 8,
  parameter int PREG_W   = 4,
  parameter int AREG_W   = 4,
  parameter int WB_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic                         alloc_has_dest,
  input  logic [AREG_W-1:0]            alloc_areg,
  input  logic [PREG_W-1:0]            alloc_preg,
  input  logic [PREG_W-1:0]            alloc_old_preg,
  output logic [IDW-1:0]               alloc_id,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*IDW-1:0]      wb_id,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_value,
  input  logic [WB_PORTS*2-1:0]        wb_flags,
  output logic [WB_PORTS-1:0]          prf_wr_valid,
  output logic [WB_PORTS*PREG_W-1:0]   prf_wr_preg,
  output logic [WB_PORTS*DATA_W-1:0]   prf_wr_value,
  output logic                         commit_valid,
  output logic [AREG_W-1:0]            commit_areg,
  output logic [PREG_W-1:0]            commit_preg,
  output logic                         free_valid,
  output logic [PREG_W-1:0]            free_preg,
  output logic                         redirect_valid,
  output logic [DATA_W-1:0]            redirect_pc,
  output logic                         halted,
  output logic [IDW:0]                 count
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  r_done;
  logic [DEPTH-1:0]  r_has_dest;
  logic [AREG_W-1:0] r_areg     [DEPTH];
  logic [PREG_W-1:0] r_preg     [DEPTH];
  logic [PREG_W-1:0] r_old_preg [DEPTH];
  logic [DATA_W-1:0] r_value    [DEPTH];
  logic [1:0]        r_flags    [DEPTH];

  logic [IDW-1:0] r_head;
  logic [IDW-1:0] r_tail;
  logic [IDW:0]   r_count;

  logic [WB_PORTS-1:0]        r_prf_v;
  logic [WB_PORTS*PREG_W-1:0] r_prf_preg;
  logic [WB_PORTS*DATA_W-1:0] r_prf_val;
  logic                       r_cmt_v;
  logic [AREG_W-1:0]          r_cmt_areg;
  logic [PREG_W-1:0]          r_cmt_preg;
  logic                       r_free_v;
  logic [PREG_W-1:0]          r_free_preg;
  logic                       r_redir_v;
  logic [DATA_W-1:0]          r_redir_pc;

  logic [IDW-1:0]      w_wb_id [WB_PORTS];
  logic [WB_PORTS-1:0] w_acc;
  logic                w_head_rdy;
  logic                w_flush_now;
  logic                w_commit;
  logic                w_flush;
  logic                w_alloc;

  for (genvar g = 0; g < WB_PORTS; g++) begin : g_id
    assign w_wb_id[g] = wb_id[g*IDW +: IDW];
  end

  assign w_head_rdy  = r_busy[r_head] && r_done[r_head];
  assign w_flush_now = w_head_rdy && r_flags[r_head][0];
  assign w_commit    = (r_state == S_RUN) && w_head_rdy;
  assign w_flush     = w_commit && r_flags[r_head][0];
  assign alloc_ready = (r_count < (IDW+1)'(DEPTH))
                    && (r_state == S_RUN) && !w_flush_now;
  assign w_alloc     = alloc_valid && alloc_ready;

  // Writeback acceptance; the highest port wins on an id collision
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < WB_PORTS; i++) begin
      w_acc[i] = wb_valid[i]
              && r_busy[w_wb_id[i]]
              && !r_done[w_wb_id[i]]
              && (!w_flush_now || (w_wb_id[i] == r_head));
      for (int j = i + 1; j < WB_PORTS; j++) begin
        if (wb_valid[j] && (w_wb_id[j] == w_wb_id[i])) begin
          w_acc[i] = 1'b0;
        end
      end
    end
  end

  // Run/halt next state: a committing halt entry stops the machine
  always_comb begin
    w_state_nx = r_state;
    if (w_commit && r_flags[r_head][1]) begin
      w_state_nx = S_HALTED;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nx;
  end

  // Entry busy/done tracking
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_busy <= '0;
      r_done <= '0;
    end else begin
      if (w_commit) begin
        r_busy[r_head] <= 1'b0;
        r_done[r_head] <= 1'b0;
      end
      if (w_alloc) begin
        r_busy[r_tail] <= 1'b1;
        r_done[r_tail] <= 1'b0;
      end
      for (int i = 0; i < WB_PORTS; i++) begin
        if (w_acc[i]) r_done[w_wb_id[i]] <= 1'b1;
      end
    end
  end

  // Entry payload: fields at dispatch, result and flags at writeback
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_has_dest[r_tail] <= alloc_has_dest;
      r_areg[r_tail]     <= alloc_areg;
      r_preg[r_tail]     <= alloc_preg;
      r_old_preg[r_tail] <= alloc_old_preg;
    end
    for (int i = 0; i < WB_PORTS; i++) begin
      if (w_acc[i]) begin
        r_value[w_wb_id[i]] <= wb_value[i*DATA_W +: DATA_W];
        r_flags[w_wb_id[i]] <= wb_flags[i*2 +: 2];
      end
    end
  end

  // Head/tail pointers and occupancy; a flush empties everything younger
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= r_head + 1'b1;
      r_tail  <= r_head + 1'b1;
      r_count <= '0;
    end else begin
      if (w_alloc)  r_tail <= r_tail + 1'b1;
      if (w_commit) r_head <= r_head + 1'b1;
      r_count <= r_count + (IDW+1)'(w_alloc)
                         - (IDW+1)'(w_commit);
    end
  end

  // Registered single-cycle PRF, commit, free and redirect pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prf_v     <= '0;
      r_prf_preg  <= '0;
      r_prf_val   <= '0;
      r_cmt_v     <= 1'b0;
      r_cmt_areg  <= '0;
      r_cmt_preg  <= '0;
      r_free_v    <= 1'b0;
      r_free_preg <= '0;
      r_redir_v   <= 1'b0;
      r_redir_pc  <= '0;
    end else begin
      for (int i = 0; i < WB_PORTS; i++) begin
        if (w_acc[i] && r_has_dest[w_wb_id[i]]) begin
          r_prf_v[i]                     <= 1'b1;
          r_prf_preg[i*PREG_W +: PREG_W] <= r_preg[w_wb_id[i]];
          r_prf_val[i*DATA_W +: DATA_W]  <= wb_value[i*DATA_W +: DATA_W];
        end else begin
          r_prf_v[i]                     <= 1'b0;
          r_prf_preg[i*PREG_W +: PREG_W] <= '0;
          r_prf_val[i*DATA_W +: DATA_W]  <= '0;
        end
      end
      r_cmt_v     <= w_commit;
      r_cmt_areg  <= w_commit ? r_areg[r_head] : '0;
      r_cmt_preg  <= w_commit ? r_preg[r_head] : '0;
      r_free_v    <= w_commit && r_has_dest[r_head];
      r_free_preg <= (w_commit && r_has_dest[r_head])
                   ? r_old_preg[r_head] : '0;
      r_redir_v   <= w_flush;
      r_redir_pc  <= w_flush ? r_value[r_head] : '0;
    end
  end

  assign alloc_id       = r_tail;
  assign count          = r_count;
  assign halted         = (r_state == S_HALTED);
  assign prf_wr_valid   = r_prf_v;
  assign prf_wr_preg    = r_prf_preg;
  assign prf_wr_value   = r_prf_val;
  assign commit_valid   = r_cmt_v;
  assign commit_areg    = r_cmt_areg;
  assign commit_preg    = r_cmt_preg;
  assign free_valid     = r_free_v;
  assign free_preg      = r_free_preg;
  assign redirect_valid = r_redir_v;
  assign redirect_pc    = r_redir_pc;

endmodule

// File: tb/tb_reorder_buffer_mp.sv
// Directed self-checking bench for reorder_buffer_mp.
// Linear scenario steps with hand-computed expectations.
module tb_reorder_buffer_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_ready;
  logic        alloc_has_dest;
  logic [3:0]  alloc_areg;
  logic [3:0]  alloc_preg;
  logic [3:0]  alloc_old_preg;
  logic [3:0]  alloc_id;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_id;
  logic [15:0] wb_value;
  logic [3:0]  wb_flags;
  logic [1:0]  prf_wr_valid;
  logic [7:0]  prf_wr_preg;
  logic [15:0] prf_wr_value;
  logic        commit_valid;
  logic [3:0]  commit_areg;
  logic [3:0]  commit_preg;
  logic        free_valid;
  logic [3:0]  free_preg;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halted;
  logic [4:0]  count;

  int checks = 0;
  int failures = 0;

  reorder_buffer_mp dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_has_dest(alloc_has_dest), .alloc_areg(alloc_areg),
    .alloc_preg(alloc_preg), .alloc_old_preg(alloc_old_preg),
    .alloc_id(alloc_id),
    .wb_valid(wb_valid), .wb_id(wb_id),
    .wb_value(wb_value), .wb_flags(wb_flags),
    .prf_wr_valid(prf_wr_valid), .prf_wr_preg(prf_wr_preg),
    .prf_wr_value(prf_wr_value),
    .commit_valid(commit_valid), .commit_areg(commit_areg),
    .commit_preg(commit_preg),
    .free_valid(free_valid), .free_preg(free_preg),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic alloc(input logic [3:0] a,
                       input logic [3:0] p,
                       input logic [3:0] o);
    alloc_valid    = 1'b1;
    alloc_has_dest = 1'b1;
    alloc_areg     = a;
    alloc_preg     = p;
    alloc_old_preg = o;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic wb_clear();
    wb_valid = '0;
    wb_id    = '0;
    wb_value = '0;
    wb_flags = '0;
  endtask

  task automatic wb_set(input int port,
                        input logic [3:0] id,
                        input logic [7:0] val,
                        input logic [1:0] fl);
    wb_valid[port]           = 1'b1;
    wb_id[port*4 +: 4]       = id;
    wb_value[port*8 +: 8]    = val;
    wb_flags[port*2 +: 2]    = fl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    alloc_valid    = 1'b0;
    alloc_has_dest = 1'b0;
    alloc_areg     = '0;
    alloc_preg     = '0;
    alloc_old_preg = '0;
    wb_clear();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_id", alloc_id, 0);
    chk("rst_commit", commit_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_prf", prf_wr_valid, 0);

    // Scenario 1: out-of-order completion, in-order retire
    for (int k = 0; k < 3; k++) begin
      chk("s1_alloc_id", alloc_id, k);
      alloc(4'(8 + k), 4'(5 + k), 4'(1 + k));
    end
    chk("s1_count", count, 3);
    wb_set(0, 4'd2, 8'h22, 2'b00);
    tick();
    wb_clear();
    chk("s1_prf2_v", prf_wr_valid, 2'b01);
    chk("s1_prf2_p", prf_wr_preg, 8'h07);
    chk("s1_prf2_d", prf_wr_value, 16'h0022);
    chk("s1_nocmt", commit_valid, 0);
    wb_set(0, 4'd0, 8'h20, 2'b00);
    tick();
    wb_clear();
    chk("s1_prf0_p", prf_wr_preg, 8'h05);
    chk("s1_prf0_d", prf_wr_value, 16'h0020);
    chk("s1_nocmt2", commit_valid, 0);
    wb_set(1, 4'd1, 8'h21, 2'b00);
    tick();
    wb_clear();
    chk("s1_prf1_v", prf_wr_valid, 2'b10);
    chk("s1_prf1_p", prf_wr_preg, 8'h60);
    chk("s1_prf1_d", prf_wr_value, 16'h2100);
    chk("s1_c0_v", commit_valid, 1);
    chk("s1_c0_a", commit_areg, 8);
    chk("s1_c0_p", commit_preg, 5);
    chk("s1_c0_fv", free_valid, 1);
    chk("s1_c0_f", free_preg, 1);
    tick();
    chk("s1_c1_v", commit_valid, 1);
    chk("s1_c1_p", commit_preg, 6);
    chk("s1_c1_f", free_preg, 2);
    chk("s1_c1_prf", prf_wr_valid, 0);
    tick();
    chk("s1_c2_v", commit_valid, 1);
    chk("s1_c2_p", commit_preg, 7);
    chk("s1_c2_f", free_preg, 3);
    tick();
    chk("s1_idle", commit_valid, 0);
    chk("s1_empty", count, 0);

    // Scenario 2: full buffer, no bypass, pointer wrap
    do_reset();
    for (int k = 0; k < 16; k++) begin
      alloc(4'(k), 4'(k), 4'(k));
    end
    chk("s2_full_cnt", count, 16);
    chk("s2_full_rdy", alloc_ready, 0);
    wb_set(0, 4'd0, 8'h55, 2'b00);
    alloc_valid = 1'b1;
    tick();
    wb_clear();
    chk("s2_still_full", alloc_ready, 0);
    tick();
    chk("s2_cmt_v", commit_valid, 1);
    chk("s2_cmt_p", commit_preg, 0);
    chk("s2_cnt15", count, 15);
    chk("s2_rdy", alloc_ready, 1);
    chk("s2_wrap_id", alloc_id, 0);
    alloc_valid = 1'b0;

    // Scenario 3: mispredict flush and redirect
    do_reset();
    for (int k = 0; k < 5; k++) begin
      alloc(4'(k), 4'(k + 1), 4'(k));
    end
    wb_set(0, 4'd0, 8'h40, 2'b01);
    wb_set(1, 4'd1, 8'h11, 2'b00);
    tick();
    wb_clear();
    chk("s3_prf_v", prf_wr_valid, 2'b11);
    chk("s3_prf_p", prf_wr_preg, 8'h21);
    chk("s3_prf_d", prf_wr_value, 16'h1140);
    chk("s3_flush_rdy", alloc_ready, 0);
    wb_set(0, 4'd2, 8'h12, 2'b00);
    wb_set(1, 4'd3, 8'h13, 2'b00);
    tick();
    wb_clear();
    chk("s3_cmt_v", commit_valid, 1);
    chk("s3_cmt_a", commit_areg, 0);
    chk("s3_redir_v", redirect_valid, 1);
    chk("s3_redir_pc", redirect_pc, 8'h40);
    chk("s3_cnt", count, 0);
    chk("s3_prf_ign", prf_wr_valid, 0);
    chk("s3_next_id", alloc_id, 1);
    chk("s3_rdy", alloc_ready, 1);
    wb_set(0, 4'd4, 8'h14, 2'b00);
    tick();
    wb_clear();
    chk("s3_prf_dead", prf_wr_valid, 0);
    chk("s3_no_cmt", commit_valid, 0);
    chk("s3_redir_pulse", redirect_valid, 0);
    tick();
    chk("s3_no_cmt2", commit_valid, 0);

    // Scenario 4: same-id writeback on both ports
    do_reset();
    for (int k = 0; k < 4; k++) begin
      alloc(4'(k), 4'(5 + k), 4'(k));
    end
    wb_set(0, 4'd3, 8'hAA, 2'b00);
    wb_set(1, 4'd3, 8'hBB, 2'b01);
    tick();
    wb_clear();
    chk("s4_prf_v", prf_wr_valid, 2'b10);
    chk("s4_prf_p", prf_wr_preg, 8'h80);
    chk("s4_prf_d", prf_wr_value, 16'hBB00);
    wb_set(0, 4'd0, 8'h01, 2'b00);
    wb_set(1, 4'd1, 8'h02, 2'b00);
    tick();
    wb_clear();
    wb_set(0, 4'd2, 8'h03, 2'b00);
    tick();
    wb_clear();
    chk("s4_c0", commit_preg, 5);
    tick();
    tick();
    chk("s4_c2", commit_preg, 7);
    chk("s4_c2_nored", redirect_valid, 0);
    tick();
    chk("s4_c3", commit_preg, 8);
    chk("s4_redir_v", redirect_valid, 1);
    chk("s4_stored", redirect_pc, 8'hBB);
    chk("s4_cnt", count, 0);

    // Scenario 5: halt at commit
    do_reset();
    alloc(4'd3, 4'd9, 4'd4);
    alloc(4'd5, 4'd10, 4'd6);
    wb_set(0, 4'd0, 8'h00, 2'b10);
    tick();
    wb_clear();
    chk("s5_pre_halt", halted, 0);
    tick();
    chk("s5_cmt_v", commit_valid, 1);
    chk("s5_cmt_a", commit_areg, 3);
    chk("s5_free", free_preg, 4);
    chk("s5_halted", halted, 1);
    chk("s5_rdy", alloc_ready, 0);
    wb_set(1, 4'd1, 8'h77, 2'b00);
    tick();
    wb_clear();
    chk("s5_prf_v", prf_wr_valid, 2'b10);
    chk("s5_prf_d", prf_wr_value, 16'h7700);
    chk("s5_no_cmt", commit_valid, 0);
    tick();
    chk("s5_no_cmt2", commit_valid, 0);
    chk("s5_stay", halted, 1);
    chk("s5_cnt", count, 1);
    do_reset();
    chk("s5_rst_h", halted, 0);
    chk("s5_rst_c", count, 0);
    chk("s5_rst_r", alloc_ready, 1);

    // Scenario 6: reset mid-operation
    for (int k = 0; k < 6; k++) begin
      alloc(4'(k), 4'(k), 4'(k));
    end
    chk("s6_cnt", count, 6);
    wb_set(0, 4'd0, 8'h99, 2'b00);
    tick();
    wb_clear();
    chk("s6_prf_pre", prf_wr_valid, 2'b01);
    rst = 1'b1;
    wb_set(0, 4'd1, 8'h98, 2'b01);
    tick();
    rst = 1'b0;
    wb_clear();
    chk("s6_prf", prf_wr_valid, 0);
    chk("s6_prf_d", prf_wr_value, 0);
    chk("s6_cmt", commit_valid, 0);
    chk("s6_free", free_valid, 0);
    chk("s6_redir", redirect_valid, 0);
    chk("s6_halt", halted, 0);
    chk("s6_cnt0", count, 0);
    chk("s6_id", alloc_id, 0);
    tick();
    chk("s6_no_cmt", commit_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reorder_buffer_mp.md
Name: reorder_buffer_mp

Overview:
Parametrised in-order-commit reorder buffer for the out-of-order core. Entries are allocated at dispatch and completed by multiple writeback ports in any order. Each completed result is forwarded to the PRF, entries retire strictly in program order, and the block frees old physical registers. A mispredicted branch at commit flushes all younger entries and redirects fetch; a halt at commit stops the machine.

Parameters:
DEPTH, 16, number of entries (power of 2, >=4)
IDW, $clog2(DEPTH), entry-id width
DATA_W, 8, result/PC width
PREG_W, 4, physical register index width
AREG_W, 4, architectural register index width
WB_PORTS, 2, number of writeback ports

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_valid  in  1  dispatch requests an entry
alloc_ready  out  1  entry available (combinational)
alloc_has_dest  in  1  instruction writes a register
alloc_areg  in  AREG_W  destination arch reg
alloc_preg  in  PREG_W  newly mapped phys reg
alloc_old_preg  in  PREG_W  previous mapping, freed at commit
alloc_id  out  IDW  id assigned on handshake (= tail, combinational)
wb_valid  in  WB_PORTS  per-port completion strobe
wb_id  in  WB_PORTS*IDW  per-port entry id, packed
wb_value  in  WB_PORTS*DATA_W  result, or target PC for branches
wb_flags  in  WB_PORTS*2  bit0 mispredict, bit1 halt
prf_wr_valid  out  WB_PORTS  registered PRF write strobes
prf_wr_preg  out  WB_PORTS*PREG_W  PRF write index
prf_wr_value  out  WB_PORTS*DATA_W  PRF write data
commit_valid  out  1  one entry retired
commit_areg  out  AREG_W  retired arch reg
commit_preg  out  PREG_W  retired phys reg
free_valid  out  1  old_preg released
free_preg  out  PREG_W  released phys reg
redirect_valid  out  1  flush + fetch redirect
redirect_pc  out  DATA_W  redirect target
halted  out  1  machine halted
count  out  IDW+1  occupied entries

Behaviour:
- Reset (rst synchronous, active-high; clock clk): head=tail=0, count=0, all busy/done cleared, state RUN. All registered outputs are 0. Reset mid-operation discards every entry.
- Per entry: busy, done, has_dest, areg, preg, old_preg, value, flags.
- Allocation fires when alloc_valid && alloc_ready.
  - The entry at tail gets busy=1, done=0, fields stored. tail wraps modulo DEPTH.
  - alloc_ready = (count<DEPTH) && state==RUN && !flush_now, where flush_now = head busy&&done&&flags[0].
  - A full buffer with a commit in the same cycle still refuses allocation (no bypass).
- Writeback on port i with wb_valid[i]:
  - If entry wb_id[i] is busy && !done, store value and flags and set done.
  - Writebacks to non-busy or already-done entries are ignored.
  - Two ports hitting the same id in one cycle: the higher port index wins, and only that port forwards to the PRF.
  - Writebacks in a flush_now cycle are ignored for all entries except head.
  - Next cycle: prf_wr_valid[i]=1 iff the write was accepted and has_dest=1, with prf_wr_preg = entry preg and prf_wr_value = wb_value. Latency is 1 cycle.
- Commit: at most one per cycle, only in RUN, when the head entry is busy&&done.
  - Next cycle: commit_valid=1 with areg/preg. free_valid=has_dest with free_preg=old_preg.
  - The head entry is cleared, head increments with wrap, count decrements. Allocation in the same cycle nets count unchanged.
  - flags[0]: next cycle redirect_valid=1 and redirect_pc=value. In the commit cycle all younger entries are cleared, tail<=head+1, count<=0.
  - flags[1]: the entry commits normally and state goes to HALTED; halted=1 from the next cycle. In HALTED there is no commit and no allocation; writebacks are still recorded and forwarded. Only rst exits HALTED.
  - If both flags are set: both redirect and halt.
- All commit, redirect and PRF outputs are single-cycle pulses.
- Pointer wrap: head/tail are IDW bits. Full vs empty is distinguished only by count.

Test Plan:
- Alloc 3 (ids 0,1,2, preg 5,6,7, old 1,2,3). WB id2 then id0 then id1, one per cycle -> prf_wr at +1 cycle each. Commits occur in order 0,1,2 on consecutive cycles after id1 completes, with free_preg 1,2,3.
- Fill 16 entries -> alloc_ready=0 with count=16. Complete id0 -> one commit, then alloc_ready=1 and next alloc_id=0 (wrap).
- Alloc ids 0–4. WB id0 flags=01, value=0x40; WB ids 1–4 -> commit id0, redirect_valid=1, redirect_pc=0x40, count=0, no commits for ids 1–4, next alloc_id=1.
- Same-cycle WB on ports 0 and 1 to id3, values 0xAA/0xBB -> stored and forwarded value is 0xBB, with a single prf_wr_valid on port 1.
- Entry id0 completes with flags=10 -> commit, halted=1, alloc_ready=0, no further commits. rst -> halted=0, count=0.
- Assert rst with 6 busy entries and a WB in flight -> all outputs 0 next cycle and count=0.
